// File: rtl/hetic_pkg.sv
// Shared types for the HETI interrupt arbiter: line candidate record, winner
// ordering and post-acknowledge flush lengths for both pipeline configurations.
package hetic_pkg;

    // Candidate fields are sized for the 64-line / 32-level controller.
    localparam int unsigned CandIdWidth   = 6;
    localparam int unsigned CandPrioWidth = 5;

    localparam int unsigned FlushCyclesReg  = 3;
    localparam int unsigned FlushCyclesComb = 2;

    typedef struct packed {
        logic                     valid;
        logic [CandIdWidth-1:0]   id;
        logic [CandPrioWidth-1:0] prio;
        logic                     heti;
        logic                     nest;
    } irq_cand_t;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbOffer,
        ArbFlush
    } arb_state_e;

    // Higher priority wins; equal priority resolves to the lower line index.
    function automatic logic cand_wins(input irq_cand_t a, input irq_cand_t b);
        return a.valid && (!b.valid || (a.prio > b.prio) ||
                           ((a.prio == b.prio) && (a.id < b.id)));
    endfunction

endpackage

// File: rtl/hetic_arb_if.sv
// Core-side handshake of the HETI arbiter: offered interrupt, acknowledge and
// the one-cycle claim returned to the line registers.
interface hetic_arb_if #(
    parameter int unsigned IrqWidth  = 6,
    parameter int unsigned PrioWidth = 5
);
    logic                 irq_valid;
    logic [IrqWidth-1:0]  irq_id;
    logic [PrioWidth-1:0] irq_level;
    logic                 irq_heti;
    logic                 irq_nest;
    logic                 irq_ack;
    logic                 claim;
    logic [IrqWidth-1:0]  claim_id;

    modport master (
        output irq_valid, irq_id, irq_level, irq_heti, irq_nest, claim, claim_id,
        input  irq_ack
    );

    modport slave (
        input  irq_valid, irq_id, irq_level, irq_heti, irq_nest, claim, claim_id,
        output irq_ack
    );
endinterface

// File: rtl/hetic_arb_group.sv
// First-stage reduction: picks the best enabled, pending, non-zero-priority
// line out of one group of GroupSize lines (purely combinational).
module hetic_arb_group
    import hetic_pkg::*;
#(
    parameter int unsigned GroupSize = 8,
    parameter int unsigned PrioWidth = 5,
    parameter int unsigned BaseId    = 0
) (
    input  logic [GroupSize-1:0]           line_ie_i,
    input  logic [GroupSize-1:0]           line_ip_i,
    input  logic [GroupSize-1:0]           line_heti_i,
    input  logic [GroupSize-1:0]           line_nest_i,
    input  logic [GroupSize*PrioWidth-1:0] line_prio_i,
    output irq_cand_t                      cand_o
);

    irq_cand_t cur;

    always_comb begin
        cand_o = '0;
        cur    = '0;
        for (int unsigned i = 0; i < GroupSize; i++) begin
            cur.id    = CandIdWidth'(BaseId + i);
            cur.prio  = CandPrioWidth'(line_prio_i[i*PrioWidth +: PrioWidth]);
            cur.valid = line_ie_i[i] & line_ip_i[i] & (cur.prio != '0);
            cur.heti  = line_heti_i[i];
            cur.nest  = line_nest_i[i];
            if (cand_wins(cur, cand_o)) begin
                cand_o = cur;
            end
        end
    end

endmodule

// File: rtl/hetic_arb.sv
// HETI sequential priority arbiter: grouped two-stage reduction, threshold
// against the core level, offer/ack handshake and claim back to the controller.
// Define HETIC_ARB_STAGE2_REG_EN to register stage 2 (latency 2, flush 3).
module hetic_arb
    import hetic_pkg::*;
#(
    parameter  int unsigned NrIrqLines = 64,
    parameter  int unsigned NrIrqPrios = 32,
    parameter  int unsigned GroupSize  = 8,
    localparam int unsigned IrqWidth   = $clog2(NrIrqLines),
    localparam int unsigned PrioWidth  = $clog2(NrIrqPrios)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrIrqLines-1:0]           line_ie_i,
    input  logic [NrIrqLines-1:0]           line_ip_i,
    input  logic [NrIrqLines-1:0]           line_heti_i,
    input  logic [NrIrqLines-1:0]           line_nest_i,
    input  logic [NrIrqLines*PrioWidth-1:0] line_prio_i,
    input  logic [PrioWidth-1:0]            core_level_i,
    hetic_arb_if.master                     core
);

    localparam int unsigned NrGroups = NrIrqLines / GroupSize;

`ifdef HETIC_ARB_STAGE2_REG_EN
    localparam int unsigned FlushCycles = FlushCyclesReg;
`else
    localparam int unsigned FlushCycles = FlushCyclesComb;
`endif
    localparam logic [1:0] FlushInit = 2'(FlushCycles - 1);

    irq_cand_t  grp_cand [NrGroups];
    irq_cand_t  s1_q     [NrGroups];
    irq_cand_t  s2_red;
    irq_cand_t  s2_elig;
    irq_cand_t  win;

    arb_state_e state_q, state_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic       offer;
    logic       take;
    logic       claim_q;
    logic [IrqWidth-1:0] claim_id_q;

    for (genvar g = 0; g < NrGroups; g++) begin : g_group
        hetic_arb_group #(
            .GroupSize (GroupSize),
            .PrioWidth (PrioWidth),
            .BaseId    (g * GroupSize)
        ) u_group (
            .line_ie_i   (line_ie_i  [g*GroupSize +: GroupSize]),
            .line_ip_i   (line_ip_i  [g*GroupSize +: GroupSize]),
            .line_heti_i (line_heti_i[g*GroupSize +: GroupSize]),
            .line_nest_i (line_nest_i[g*GroupSize +: GroupSize]),
            .line_prio_i (line_prio_i[g*GroupSize*PrioWidth +: GroupSize*PrioWidth]),
            .cand_o      (grp_cand[g])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned g = 0; g < NrGroups; g++) begin
                s1_q[g] <= '0;
            end
        end else begin
            for (int unsigned g = 0; g < NrGroups; g++) begin
                s1_q[g] <= grp_cand[g];
            end
        end
    end

    always_comb begin
        s2_red = '0;
        for (int unsigned g = 0; g < NrGroups; g++) begin
            if (cand_wins(s1_q[g], s2_red)) begin
                s2_red = s1_q[g];
            end
        end
        s2_elig       = s2_red;
        s2_elig.valid = s2_red.valid && (s2_red.prio > CandPrioWidth'(core_level_i));
    end

`ifdef HETIC_ARB_STAGE2_REG_EN
    irq_cand_t s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_q <= '0;
        end else begin
            s2_q <= s2_elig;
        end
    end

    assign win = s2_q;
`else
    assign win = s2_elig;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ArbIdle;
            flush_cnt_q <= '0;
            claim_q     <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            claim_q     <= take;
            if (take) begin
                claim_id_q <= IrqWidth'(win.id);
            end
        end
    end

    // The offer is raised in the same cycle the winner appears, so the
    // line-to-valid latency equals the pipeline depth; IDLE and OFFER differ
    // only in what was presented on the previous cycle.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        offer       = 1'b0;
        take        = 1'b0;
        unique case (state_q)
            ArbIdle, ArbOffer: begin
                if (win.valid) begin
                    offer   = 1'b1;
                    state_d = ArbOffer;
                    if (core.irq_ack) begin
                        take        = 1'b1;
                        state_d     = ArbFlush;
                        flush_cnt_d = FlushInit;
                    end
                end else begin
                    state_d = ArbIdle;
                end
            end
            ArbFlush: begin
                if (flush_cnt_q == '0) begin
                    state_d = ArbIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    assign core.irq_valid = offer;
    assign core.irq_id    = offer ? IrqWidth'(win.id)    : '0;
    assign core.irq_level = offer ? PrioWidth'(win.prio) : '0;
    assign core.irq_heti  = offer & win.heti;
    assign core.irq_nest  = offer & win.nest;
    assign core.claim     = claim_q;
    assign core.claim_id  = claim_id_q;

endmodule

// File: tb/tb_hetic_arb.sv
// Scoreboard bench for hetic_arb: directed scenarios then random line traffic,
// expectations from a flat whole-line-table reference model.
module tb_hetic_arb;

    localparam int NL   = 64;
    localparam int PW   = 5;
    localparam int IW   = 6;
    localparam int MAXC = 4096;
`ifdef HETIC_ARB_STAGE2_REG_EN
    localparam int LAT = 2;
    localparam int FL  = 3;
`else
    localparam int LAT = 1;
    localparam int FL  = 2;
`endif

    typedef struct {
        int          cyc;
        logic        valid;
        logic [5:0]  id;
        logic [4:0]  level;
        logic        heti;
        logic        nest;
        logic        claim;
        logic [5:0]  claim_id;
    } exp_t;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [NL-1:0]      ie, ip, heti, nest;
    logic [NL*PW-1:0]   prio;
    logic [PW-1:0]      lvl;

    hetic_arb_if #(.IrqWidth(IW), .PrioWidth(PW)) core_if ();

    hetic_arb #(
        .NrIrqLines (NL),
        .NrIrqPrios (32),
        .GroupSize  (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .line_ie_i    (ie),
        .line_ip_i    (ip),
        .line_heti_i  (heti),
        .line_nest_i  (nest),
        .line_prio_i  (prio),
        .core_level_i (lvl),
        .core         (core_if)
    );

    always #5 clk_i = ~clk_i;

    logic [NL-1:0]    h_ie [MAXC], h_ip [MAXC], h_heti [MAXC], h_nest [MAXC];
    logic [NL*PW-1:0] h_prio [MAXC];
    logic [PW-1:0]    h_lvl [MAXC];
    logic             h_rst [MAXC];

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   flush_until = -1;
    logic claim_pend  = 1'b0;
    logic [5:0] claim_pid = '0;
    logic clr_pend    = 1'b0;
    logic [5:0] clr_id = '0;
    logic running     = 1'b0;

    // Best line over the whole table: scan ascending, strictly greater wins.
    task automatic ref_win(input logic [NL-1:0] e, input logic [NL-1:0] p,
                           input logic [NL*PW-1:0] pv,
                           output logic v, output int id, output int pr);
        v = 1'b0; id = 0; pr = 0;
        for (int n = 0; n < NL; n++) begin
            int lp;
            lp = int'(pv[n*PW +: PW]);
            if (e[n] && p[n] && lp > pr) begin
                v = 1'b1; id = n; pr = lp;
            end
        end
    endtask

    task automatic set_line(input int n, input logic e, input logic p, input int pr,
                            input logic h, input logic ns);
        ie[n] = e; ip[n] = p; heti[n] = h; nest[n] = ns;
        prio[n*PW +: PW] = PW'(pr);
    endtask

    task automatic clear_lines();
        ie = '0; ip = '0; heti = '0; nest = '0; prio = '0;
    endtask

    task automatic step(input logic ack, input logic rst);
        exp_t e;
        logic in_rst, v;
        int   wid, wpr, src;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget actual=%0d required<%0d", cyc, MAXC);
            $fatal(1);
        end
        if (clr_pend) ip[clr_id] = 1'b0;
        rst_i = rst;
        core_if.irq_ack = ack;
        h_ie[cyc] = ie; h_ip[cyc] = ip; h_heti[cyc] = heti; h_nest[cyc] = nest;
        h_prio[cyc] = prio; h_lvl[cyc] = lvl; h_rst[cyc] = rst;

        in_rst = 1'b0;
        for (int k = cyc - LAT; k <= cyc; k++) begin
            if (k < 0 || h_rst[k]) in_rst = 1'b1;
        end
        if (rst) flush_until = -1;

        e.cyc = cyc; e.valid = 1'b0; e.id = '0; e.level = '0; e.heti = 1'b0; e.nest = 1'b0;
        if (!in_rst) begin
            src = cyc - LAT;
            ref_win(h_ie[src], h_ip[src], h_prio[src], v, wid, wpr);
            e.valid = v && (cyc > flush_until) && (wpr > int'(h_lvl[cyc - LAT + 1]));
            e.id    = 6'(wid);
            e.level = 5'(wpr);
            e.heti  = h_heti[src][wid];
            e.nest  = h_nest[src][wid];
        end
        e.claim    = claim_pend && !rst;
        e.claim_id = claim_pid;

        clr_pend   = e.claim;
        clr_id     = claim_pid;
        claim_pend = e.valid && ack;
        if (claim_pend) begin
            claim_pid   = e.id;
            flush_until = cyc + FL;
        end

        sb_q.push_back(e);
        running = 1'b1;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input int c, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, c, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        if (running) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", cyc, 0, 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("irq_valid", e.cyc, int'(core_if.irq_valid), int'(e.valid));
                if (e.valid) begin
                    chk("irq_id",    e.cyc, int'(core_if.irq_id),    int'(e.id));
                    chk("irq_level", e.cyc, int'(core_if.irq_level), int'(e.level));
                    chk("irq_heti",  e.cyc, int'(core_if.irq_heti),  int'(e.heti));
                    chk("irq_nest",  e.cyc, int'(core_if.irq_nest),  int'(e.nest));
                end
                chk("claim", e.cyc, int'(core_if.claim), int'(e.claim));
                if (e.claim) begin
                    chk("claim_id", e.cyc, int'(core_if.claim_id), int'(e.claim_id));
                end
            end
        end
    end

    initial begin
        clear_lines();
        lvl = '0;
        core_if.irq_ack = 1'b0;
        @(posedge clk_i);
        #1;
        repeat (3) step(1'b0, 1'b1);

        // Stray acks with nothing offered.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Single line, ack, then ack held through the flush window.
        set_line(3, 1'b1, 1'b1, 5, 1'b1, 1'b0);
        repeat (LAT) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (FL) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // Priority and tie resolution.
        clear_lines();
        set_line(10, 1'b1, 1'b1, 7, 1'b0, 1'b1);
        set_line(40, 1'b1, 1'b1, 7, 1'b1, 1'b1);
        set_line(20, 1'b1, 1'b1, 9, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        ip[20] = 1'b0;
        repeat (4) step(1'b0, 1'b0);

        // Threshold against the core level.
        clear_lines();
        set_line(5, 1'b1, 1'b1, 4, 1'b0, 1'b0);
        lvl = 5'd4;
        repeat (4) step(1'b0, 1'b0);
        lvl = 5'd3;
        repeat (4) step(1'b0, 1'b0);
        lvl = 5'd6;
        repeat (4) step(1'b0, 1'b0);
        lvl = 5'd0;

        // Higher-priority arrival replaces the current offer.
        clear_lines();
        set_line(2, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        set_line(60, 1'b1, 1'b1, 12, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);

        // Reset one cycle after ack, line left pending.
        clear_lines();
        set_line(7, 1'b1, 1'b1, 8, 1'b0, 1'b1);
        repeat (LAT) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);

        // Random line traffic, level changes, acks and occasional resets.
        repeat (2000) begin
            if ($urandom_range(0, 3) == 0) begin
                set_line(int'($urandom_range(0, NL-1)),
                         $urandom_range(0, 3) != 0,
                         1'($urandom_range(0, 1)),
                         ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)),
                         1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 15) == 0) lvl = 5'($urandom_range(0, 8));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
        end

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
